icache: RTL
===========

ICACHE -- requirements
Module: icache

Interface
REQ-001 The block SHALL have parameter NSETS, default 16, number of direct-mapped one-word frames (power of two).
REQ-002 The block SHALL have parameter IDXW, default 4, index width equal to log2(NSETS).
REQ-003 Port CLK input 1: the single clock; all state updates on its rising edge.
REQ-004 Port nRST input 1: reset, asynchronous and active-low.
REQ-005 Port imemREN input 1: datapath instruction read request.
REQ-006 Port imemaddr input 32: datapath fetch address (PC).
REQ-007 Port ihit output 1: the addressed instruction is valid on imemload this cycle.
REQ-008 Port imemload output 32: instruction word to the datapath.
REQ-009 Port iREN output 1: memory-side read request.
REQ-010 Port iaddr output 32: memory-side word address.
REQ-011 Port iwait input 1: memory busy; iload is valid in the cycle iwait=0 while iREN=1.
REQ-012 Port iload input 32: memory-side read data.

Function
REQ-013 Address split SHALL be tag=[31:IDXW+2], index=[IDXW+1:2], byte offset=[1:0]; byte offset is ignored.
REQ-014 Each frame SHALL hold valid (1 bit), tag (30-IDXW bits) and data (32 bits).
REQ-015 ihit SHALL be combinational: imemREN & state==IDLE & valid[index] & tag[index]==imemaddr tag.
REQ-016 imemload SHALL equal data[index of imemaddr] whenever ihit=1; otherwise its value is unspecified.
REQ-017 FSM states SHALL be IDLE and FETCH.
REQ-018 IDLE -> FETCH SHALL occur when imemREN=1 and no hit; miss address (imemaddr with [1:0]=00) latched into a miss register.
REQ-019 In FETCH, iREN SHALL be 1 and iaddr SHALL equal the miss register; in IDLE iREN=0 and iaddr equals the miss register.
REQ-020 In FETCH with iwait=0 the indexed frame SHALL be written (valid=1, tag and data from miss register/iload) and FSM returns to IDLE.
REQ-021 The refilled word SHALL produce ihit=1 in the cycle after the fill (miss latency = memory latency + 1 cycles).
REQ-022 In FETCH with iwait=1 and imemREN=0, FSM SHALL return to IDLE without writing the frame (abandoned fetch).
REQ-023 ihit SHALL be 0 throughout FETCH, including the fill cycle.
REQ-024 A fill SHALL unconditionally replace a valid frame at the same index (conflict eviction).
REQ-025 imemaddr changes during FETCH SHALL not alter iaddr; the latched fill completes, then the new address is looked up in IDLE.
REQ-026 imemREN=0 in IDLE SHALL hold the FSM in IDLE with ihit=0.

Reset
REQ-027 While nRST=0: state=IDLE, all valid bits=0, all tags and data=0, miss register=0.
REQ-028 Consequently during and after reset: ihit=0, iREN=0, iaddr=0, imemload=0 until the first fill.
REQ-029 Reset asserted mid-FETCH SHALL abandon the fetch immediately with no frame written.

Structure
REQ-030 word_t and a packed icache address typedef (tag, idx, bytoff fields) SHALL live in cpu_types_pkg.
REQ-031 The FSM state enum SHALL be local to icache; NSETS/IDXW remain module parameters.
REQ-032 No sub-module is required; frame storage SHALL be flop arrays inside icache.

Verification
REQ-033 Reset, then imemREN=1, imemaddr=0x00000000 -> ihit=0, iREN=1, iaddr=0x00000000 the next cycle.
REQ-034 Cold miss at 0x00000040, iwait=1 for 3 cycles then iload=0x20010005 -> frame 0 filled, ihit=1 and imemload=0x20010005 one cycle later; iREN=0.
REQ-035 Re-read 0x00000040 after fill -> ihit=1 same cycle, iREN stays 0.
REQ-036 Conflict: fill 0x00000004 then 0x00000044 (same index 1) -> read of 0x00000004 misses again and reissues iaddr=0x00000004.
REQ-037 imemREN drops during FETCH with iwait=1 -> FSM IDLE next cycle, frame unchanged, later read of same address misses.
REQ-038 nRST pulsed low mid-FETCH after a prior fill of 0x00000040 -> iREN=0 at once, 0x00000040 misses after reset release.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared CPU word and instruction-cache address types.
package cpu_types_pkg;
    typedef logic [31:0] word_t;
    localparam int ICACHE_IDXW = 4;
    localparam int ICACHE_TAGW = 30 - ICACHE_IDXW;
    typedef struct packed {
        logic [ICACHE_TAGW-1:0] tag;
        logic [ICACHE_IDXW-1:0] idx;
        logic [1:0]             bytoff;
    } icache_addr_t;
endpackage

// File: rtl/icache.sv
// icache: direct-mapped one-word-per-frame instruction cache with a two-state refill FSM.
module icache
    import cpu_types_pkg::*;
#(
    parameter int NSETS = 16,
    parameter int IDXW  = 4
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        imemREN,
    input  logic [31:0] imemaddr,
    output logic        ihit,
    output logic [31:0] imemload,
    output logic        iREN,
    output logic [31:0] iaddr,
    input  logic        iwait,
    input  logic [31:0] iload
);
    localparam int TAGW = 30 - IDXW;
    typedef enum logic {IDLE, FETCH} state_t;
    state_t            state, next_state;
    logic [NSETS-1:0]  valid;
    logic [TAGW-1:0]   tags [NSETS];
    word_t             data [NSETS];
    word_t             miss_addr;
    logic [IDXW-1:0]   idx, miss_idx;
    logic [TAGW-1:0]   tag;
    logic              lookup_hit, fill;
    assign idx        = imemaddr[IDXW+1:2];
    assign tag        = imemaddr[31:IDXW+2];
    assign miss_idx   = miss_addr[IDXW+1:2];
    assign lookup_hit = valid[idx] && tags[idx] == tag;
    assign fill       = state == FETCH && !iwait;
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST)
            state <= IDLE;
        else
            state <= next_state;
    end
    always_comb begin
        next_state = state;
        if (state == IDLE)
            next_state = (imemREN && !lookup_hit) ? FETCH : IDLE;
        else
            next_state = (!iwait || !imemREN) ? IDLE : FETCH;
    end
    always_comb begin
        ihit     = imemREN && state == IDLE && lookup_hit;
        imemload = data[idx];
        iREN     = state == FETCH;
        iaddr    = miss_addr;
    end
    // The miss address is word-aligned so the memory side never sees a byte offset.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST)
            miss_addr <= '0;
        else if (state == IDLE && next_state == FETCH)
            miss_addr <= imemaddr & 32'hFFFF_FFFC;
    end
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            valid <= '0;
            for (int i = 0; i < NSETS; i++) begin
                tags[i] <= '0;
                data[i] <= '0;
            end
        end else if (fill) begin
            valid[miss_idx] <= 1'b1;
            tags[miss_idx]  <= miss_addr[31:IDXW+2];
            data[miss_idx]  <= iload;
        end
    end
endmodule
